cofre_controle: RTL and testbench
=================================

# cofre_controle

Sequential controller for the 4-bit safe. Captures the stored password and each user attempt from the switch bank, holds both on registered buses for the combinational subtract/compare path, and samples that path's verdict one cycle later. Counts wrong attempts, locks the safe for a fixed time after too many, and owns the open/closed/locked state shown on the board LEDs. It sits between the board inputs and the comparison datapath, driving that datapath's password and attempt operands.

## Interface
- `MAX_ERROS`, 3: consecutive wrong attempts that trigger lockout (≥1).
- `BLOQ_CICLOS`, 1000: lockout duration in clock cycles (≥2).
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw` in 4: switch value used as new password or as attempt.
- `btn_gravar` in 1: one-cycle synchronous pulse; program password.
- `btn_tentar` in 1: one-cycle synchronous pulse; submit attempt, or close when open.
- `igual` in 1: comparator verdict, attempt equals password.
- `senha` out 4: registered stored password.
- `tentativa` out 4: registered last attempt.
- `aberto` out 1: safe open.
- `bloqueado` out 1: lockout active.
- `pronto` out 1: accepting an attempt (state FECHADO).
- `restantes` out $clog2(MAX_ERROS+1): attempts left before lockout.

## Operation
- States: PROGRAMAR, FECHADO, AVALIAR, ABERTO, BLOQUEADO.
- PROGRAMAR (after reset): `btn_gravar` → `senha`←`sw`, go FECHADO. `btn_tentar` ignored.
- FECHADO: `btn_tentar` → `tentativa`←`sw`, go AVALIAR. `btn_gravar` ignored.
- AVALIAR (exactly one cycle, buttons ignored): sample `igual`.
  - `igual`=1 → ABERTO, error count cleared.
  - `igual`=0, count+1 < MAX_ERROS → count+1, FECHADO.
  - `igual`=0, count+1 = MAX_ERROS → BLOQUEADO, timer loaded with BLOQ_CICLOS-1.
- ABERTO: `btn_gravar` → `senha`←`sw`, go FECHADO. `btn_tentar` alone → FECHADO, password unchanged. Both same cycle: `btn_gravar` wins.
- BLOQUEADO: timer decrements each cycle; at 0 → FECHADO, error count cleared. All buttons ignored.
- `restantes` = MAX_ERROS − error count. Reads 0 throughout BLOQUEADO.
- Decoded outputs, registered with the state: `aberto`=ABERTO, `bloqueado`=BLOQUEADO, `pronto`=FECHADO.
- `tentativa` holds its value outside the FECHADO capture. `senha` changes only on the two `btn_gravar` paths.

## Timing
- Reset (async assert, sync release) values:
  - state PROGRAMAR; `senha`=0, `tentativa`=0.
  - `aberto`=0, `bloqueado`=0, `pronto`=0.
  - `restantes`=MAX_ERROS, timer=0.
- Attempt latency: `btn_tentar` at edge N captures `tentativa`.
  - `igual` must be valid combinationally before edge N+1, where it is sampled.
  - Verdict outputs (`aberto`/`pronto`/`bloqueado`/`restantes`) update at edge N+1, visible after it.
- Lockout lasts exactly BLOQ_CICLOS cycles with `bloqueado`=1, then `pronto`=1.
- Reset mid-lockout or mid-AVALIAR: immediate return to reset values; stored password is lost.
- A pulse arriving in a state that ignores it is dropped, not queued.

## Structure
- Package `cofre_pkg`:
  - state enum `estado_t`;
  - `LARGURA_SENHA`=4;
  - default constants for MAX_ERROS and BLOQ_CICLOS.
- Sub-module `temporizador_bloqueio`: load/decrement down-counter with a `zero` flag, parameterised by BLOQ_CICLOS.
- The comparison datapath is instantiated alongside this block by the top level, not inside it.

## Test plan
- Reset, `btn_gravar` with `sw`=0101 → `senha`=0101, `pronto`=1, `restantes`=3.
- Password 0101, `btn_tentar` with `sw`=0101 (`igual`=1) → `tentativa`=0101 next edge; `aberto`=1 after the verdict edge; `restantes`=3.
- Three wrong attempts (0000, 0111, 1111) → `restantes` steps 2,1, then `bloqueado`=1 for exactly BLOQ_CICLOS cycles (test with BLOQ_CICLOS=8).
  - Afterwards `pronto`=1, `restantes`=3.
  - `btn_tentar` pulses during lockout change nothing.
- In ABERTO, `btn_gravar` and `btn_tentar` together with `sw`=1010 → `senha`=1010, state FECHADO; old password 0101 now fails.
- Two wrong attempts then a correct one → ABERTO and `restantes` back to 3; a later single wrong attempt gives `restantes`=2.
- Assert `rst_n`=0 mid-lockout → `bloqueado` drops asynchronously; `senha`=0; state PROGRAMAR after release.

Source files
------------

// File: rtl/cofre_pkg.sv
// Shared types and default constants for the 4-bit safe controller.
package cofre_pkg;

  localparam int LARGURA_SENHA      = 4;
  localparam int MAX_ERROS_PADRAO   = 3;
  localparam int BLOQ_CICLOS_PADRAO = 1000;

  typedef enum logic [2:0] {
    PROGRAMAR,
    FECHADO,
    AVALIAR,
    ABERTO,
    BLOQUEADO
  } estado_t;

endpackage

// File: rtl/temporizador_bloqueio.sv
// Lockout down-counter: load BLOQ_CICLOS-1, decrement to zero and hold there.
module temporizador_bloqueio #(
  parameter int BLOQ_CICLOS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic carregar,
  input  logic decrementar,
  output logic zero
);

  localparam int W = (BLOQ_CICLOS > 2) ? $clog2(BLOQ_CICLOS) : 1;

  logic [W-1:0] contagem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
    end else if (carregar) begin
      contagem <= W'(BLOQ_CICLOS - 1);
    end else if (decrementar && (contagem != '0)) begin
      contagem <= contagem - W'(1);
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/cofre_controle.sv
// Safe controller: captures password/attempt operands, samples the external
// comparator verdict one cycle after capture, and handles error lockout.
module cofre_controle
  import cofre_pkg::*;
#(
  parameter  int MAX_ERROS   = MAX_ERROS_PADRAO,
  parameter  int BLOQ_CICLOS = BLOQ_CICLOS_PADRAO,
  localparam int LR          = $clog2(MAX_ERROS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LARGURA_SENHA-1:0] sw,
  input  logic                     btn_gravar,
  input  logic                     btn_tentar,
  input  logic                     igual,
  output logic [LARGURA_SENHA-1:0] senha,
  output logic [LARGURA_SENHA-1:0] tentativa,
  output logic                     aberto,
  output logic                     bloqueado,
  output logic                     pronto,
  output logic [LR-1:0]            restantes
);

  estado_t         estado, estado_prox;
  logic [LR-1:0]   erros, erros_prox, erros_inc;
  logic            grava, captura, carregar, tempo_zero;

  assign erros_inc = erros + LR'(1);

  temporizador_bloqueio #(
    .BLOQ_CICLOS (BLOQ_CICLOS)
  ) u_temporizador (
    .clk         (clk),
    .rst_n       (rst_n),
    .carregar    (carregar),
    .decrementar (estado == BLOQUEADO),
    .zero        (tempo_zero)
  );

  always_comb begin
    estado_prox = estado;
    erros_prox  = erros;
    grava       = 1'b0;
    captura     = 1'b0;
    carregar    = 1'b0;
    case (estado)
      PROGRAMAR: begin
        if (btn_gravar) begin
          grava       = 1'b1;
          estado_prox = FECHADO;
        end
      end
      FECHADO: begin
        if (btn_tentar) begin
          captura     = 1'b1;
          estado_prox = AVALIAR;
        end
      end
      AVALIAR: begin
        // igual is valid here because tentativa was registered last edge
        if (igual) begin
          erros_prox  = '0;
          estado_prox = ABERTO;
        end else if (erros_inc < LR'(MAX_ERROS)) begin
          erros_prox  = erros_inc;
          estado_prox = FECHADO;
        end else begin
          erros_prox  = LR'(MAX_ERROS);
          carregar    = 1'b1;
          estado_prox = BLOQUEADO;
        end
      end
      ABERTO: begin
        if (btn_gravar) begin
          grava       = 1'b1;
          estado_prox = FECHADO;
        end else if (btn_tentar) begin
          estado_prox = FECHADO;
        end
      end
      BLOQUEADO: begin
        if (tempo_zero) begin
          erros_prox  = '0;
          estado_prox = FECHADO;
        end
      end
      default: estado_prox = PROGRAMAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= PROGRAMAR;
      erros     <= '0;
      senha     <= '0;
      tentativa <= '0;
      aberto    <= 1'b0;
      bloqueado <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      estado    <= estado_prox;
      erros     <= erros_prox;
      if (grava)   senha     <= sw;
      if (captura) tentativa <= sw;
      aberto    <= (estado_prox == ABERTO);
      bloqueado <= (estado_prox == BLOQUEADO);
      pronto    <= (estado_prox == FECHADO);
    end
  end

  // Error count saturates at MAX_ERROS in lockout, so this reads 0 there.
  assign restantes = LR'(MAX_ERROS) - erros;

endmodule

// File: tb/tb_cofre_controle.sv
// Scoreboard bench: driver steps a reference model and queues expected
// outputs; a monitor pops and compares after every clock edge.
module tb_cofre_controle;

  localparam int MAXE = 3;
  localparam int BLOQ = 8;

  localparam int M_PROG = 0;
  localparam int M_FECH = 1;
  localparam int M_AVAL = 2;
  localparam int M_ABER = 3;
  localparam int M_BLOQ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_gravar = 1'b0;
  logic       btn_tentar = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       igual;
  logic [3:0] senha, tentativa;
  logic       aberto, bloqueado, pronto;
  logic [1:0] restantes;

  always #5 clk = ~clk;

  // Stand-in for the external comparison datapath.
  assign igual = (senha == tentativa);

  cofre_controle #(
    .MAX_ERROS   (MAXE),
    .BLOQ_CICLOS (BLOQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_gravar (btn_gravar),
    .btn_tentar (btn_tentar),
    .igual      (igual),
    .senha      (senha),
    .tentativa  (tentativa),
    .aberto     (aberto),
    .bloqueado  (bloqueado),
    .pronto     (pronto),
    .restantes  (restantes)
  );

  typedef struct packed {
    logic [3:0] senha;
    logic [3:0] tent;
    logic       aberto;
    logic       bloq;
    logic       pronto;
    logic [1:0] rest;
  } obs_t;

  obs_t atual;
  assign atual = {senha, tentativa, aberto, bloqueado, pronto, restantes};

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;

  int         m_modo;
  logic [3:0] m_senha, m_tent;
  int         m_falhas;
  int         m_ciclos_bloq;

  function automatic obs_t valores_reset();
    obs_t r;
    r.senha  = 4'd0;
    r.tent   = 4'd0;
    r.aberto = 1'b0;
    r.bloq   = 1'b0;
    r.pronto = 1'b0;
    r.rest   = 2'(MAXE);
    return r;
  endfunction

  function automatic obs_t esperado();
    obs_t r;
    r.senha  = m_senha;
    r.tent   = m_tent;
    r.aberto = (m_modo == M_ABER);
    r.bloq   = (m_modo == M_BLOQ);
    r.pronto = (m_modo == M_FECH);
    r.rest   = (m_modo == M_BLOQ) ? 2'd0 : 2'(MAXE - m_falhas);
    return r;
  endfunction

  task automatic modelo_reset();
    m_modo        = M_PROG;
    m_senha       = 4'd0;
    m_tent        = 4'd0;
    m_falhas      = 0;
    m_ciclos_bloq = 0;
  endtask

  task automatic modelo(input logic g, input logic t, input logic [3:0] s);
    case (m_modo)
      M_PROG: if (g) begin m_senha = s; m_modo = M_FECH; end
      M_FECH: if (t) begin m_tent = s; m_modo = M_AVAL; end
      M_AVAL: begin
        if (m_tent == m_senha) begin
          m_falhas = 0;
          m_modo   = M_ABER;
        end else if (m_falhas + 1 < MAXE) begin
          m_falhas++;
          m_modo = M_FECH;
        end else begin
          m_falhas      = MAXE;
          m_ciclos_bloq = BLOQ;
          m_modo        = M_BLOQ;
        end
      end
      M_ABER: begin
        if (g) begin m_senha = s; m_modo = M_FECH; end
        else if (t) m_modo = M_FECH;
      end
      M_BLOQ: begin
        m_ciclos_bloq--;
        if (m_ciclos_bloq == 0) begin
          m_falhas = 0;
          m_modo   = M_FECH;
        end
      end
      default: m_modo = M_PROG;
    endcase
  endtask

  task automatic ciclo(input logic g, input logic t, input logic [3:0] s);
    @(negedge clk);
    btn_gravar = g;
    btn_tentar = t;
    sw         = s;
    modelo(g, t, s);
    q.push_back(esperado());
  endtask

  task automatic tentativa_completa(input logic [3:0] s);
    ciclo(1'b0, 1'b1, s);
    ciclo(1'b0, 1'b0, 4'd0);
  endtask

  task automatic verifica(input string nome, input obs_t exp);
    checks++;
    if (atual !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got senha=%h tent=%h ab=%b bl=%b pr=%b rest=%0d expected senha=%h tent=%h ab=%b bl=%b pr=%b rest=%0d",
               nome, $time, atual.senha, atual.tent, atual.aberto, atual.bloq, atual.pronto, atual.rest,
               exp.senha, exp.tent, exp.aberto, exp.bloq, exp.pronto, exp.rest);
    end
  endtask

  task automatic reset_assinc();
    @(negedge clk);
    btn_gravar = 1'b0;
    btn_tentar = 1'b0;
    #1 rst_n = 1'b0;
    #1 verifica("reset_assinc", valores_reset());
    @(negedge clk);
    rst_n = 1'b1;
    modelo_reset();
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        verifica("scoreboard", e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin : estimulo
    logic g, t;
    logic [3:0] s;
    int r;
    modelo_reset();
    #12 verifica("reset_inicial", valores_reset());
    @(negedge clk);
    rst_n = 1'b1;

    ciclo(1'b0, 1'b1, 4'd3);          // ignored while programming
    ciclo(1'b1, 1'b0, 4'b0101);
    tentativa_completa(4'b0101);      // opens
    ciclo(1'b0, 1'b1, 4'd0);          // close, password kept
    tentativa_completa(4'b0000);
    tentativa_completa(4'b0111);
    tentativa_completa(4'b1111);      // lockout
    for (int i = 0; i < 12; i++) ciclo(1'b0, 1'(i % 2), 4'b0101);
    tentativa_completa(4'b0101);
    ciclo(1'b1, 1'b1, 4'b1010);       // gravar wins
    tentativa_completa(4'b0101);      // old password fails
    tentativa_completa(4'b0001);
    tentativa_completa(4'b1010);      // opens, count cleared
    ciclo(1'b0, 1'b1, 4'd0);
    tentativa_completa(4'b0011);      // restantes = 2
    tentativa_completa(4'b0011);
    tentativa_completa(4'b0011);      // lockout
    ciclo(1'b0, 1'b0, 4'd0);
    ciclo(1'b0, 1'b1, 4'd0);
    reset_assinc();
    ciclo(1'b0, 1'b1, 4'b1010);       // still programming after release
    ciclo(1'b0, 1'b0, 4'd0);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 199));
      if (r == 199) begin
        reset_assinc();
      end else begin
        g = (r < 30);
        t = (r >= 30) && (r < 110);
        s = ($urandom_range(0, 1) == 1) ? m_senha : 4'($urandom_range(0, 15));
        ciclo(g, t, s);
      end
    end

    ciclo(1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_vazio got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
